seq_pattern_gen: RTL

Serial pattern transmitter. Loads a pattern word and shifts it out MSB-first, one bit per clock, as a programmable number of repetitions with optional idle gaps between them. Drives the serial input of the Mealy sequence detectors (e.g. seq_d001) in system-level tests and on-chip self-test. It is the transmit end of the single-bit serial stream those detectors receive.

---
 rtl/seq_gen_pkg.sv | 15 +
 rtl/seq_shift_out.sv | 49 ++++
 rtl/seq_pattern_gen.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/seq_gen_pkg.sv
// rtl/seq_gen_pkg.sv - shared state type and default widths for the serial pattern generator
package seq_gen_pkg;

    localparam int DEF_PAT_W = 8;
    localparam int DEF_REP_W = 8;
    localparam int DEF_GAP_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2,
        ST_FIN  = 2'd3
    } seq_state_e;

endpackage

// File: rtl/seq_shift_out.sv
// rtl/seq_shift_out.sv - left-aligned PISO with bit-index down-counter
module seq_shift_out
    import seq_gen_pkg::*;
#(
    parameter int   PAT_W    = DEF_PAT_W,
    parameter int   LEN_W    = $clog2(DEF_PAT_W + 1),
    parameter logic IDLE_BIT = 1'b1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_load,
    input  logic             i_shift,
    input  logic [PAT_W-1:0] i_pat,
    input  logic [LEN_W-1:0] i_len,
    output logic             o_bit,
    output logic             o_last
);

    logic [PAT_W-1:0] r_sreg;
    logic [LEN_W-1:0] r_idx;
    logic [LEN_W-1:0] w_sh;
    logic [PAT_W-1:0] w_loaded;

    // Pattern sits in the top len bits, IDLE_BIT below, so the MSB drops to
    // IDLE_BIT by itself after the last bit; loading len=0 parks the line idle.
    always_comb begin
        w_sh     = LEN_W'(PAT_W) - i_len;
        w_loaded = (i_pat << w_sh) | ({PAT_W{IDLE_BIT}} >> i_len);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sreg <= {PAT_W{IDLE_BIT}};
            r_idx  <= '0;
        end else if (i_load) begin
            r_sreg <= w_loaded;
            r_idx  <= (i_len == '0) ? '0 : i_len - LEN_W'(1);
        end else if (i_shift) begin
            r_sreg <= {r_sreg[PAT_W-2:0], IDLE_BIT};
            if (r_idx != '0) begin
                r_idx <= r_idx - LEN_W'(1);
            end
        end
    end

    assign o_bit  = r_sreg[PAT_W-1];
    assign o_last = (r_idx == '0);

endmodule

// File: rtl/seq_pattern_gen.sv
// rtl/seq_pattern_gen.sv - repeating MSB-first serial pattern transmitter with idle gaps
module seq_pattern_gen
    import seq_gen_pkg::*;
#(
    parameter int   PAT_W    = DEF_PAT_W,
    parameter int   REP_W    = DEF_REP_W,
    parameter int   GAP_W    = DEF_GAP_W,
    parameter logic IDLE_BIT = 1'b1
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_start,
    input  logic [PAT_W-1:0]           i_pat,
    input  logic [$clog2(PAT_W+1)-1:0] i_len,
    input  logic [REP_W-1:0]           i_reps,
    input  logic [GAP_W-1:0]           i_gap,
    input  logic                       i_abort,
    output logic                       o_dout,
    output logic                       o_dout_vld,
    output logic                       o_busy,
    output logic                       o_done
);

    localparam int LEN_W = $clog2(PAT_W + 1);

    seq_state_e       r_state;
    logic [PAT_W-1:0] r_pat;
    logic [LEN_W-1:0] r_len;
    logic [REP_W-1:0] r_rep;
    logic [GAP_W-1:0] r_gap;
    logic [GAP_W-1:0] r_gap_cnt;
    logic             r_vld;

    logic [LEN_W-1:0] w_len_clamp;
    logic             w_busy;
    logic             w_abort;
    logic             w_empty;
    logic             w_rep_more;
    logic             w_bit;
    logic             w_last;
    logic             w_load;
    logic             w_shift;
    logic [PAT_W-1:0] w_ld_pat;
    logic [LEN_W-1:0] w_ld_len;

    assign w_len_clamp = (i_len > LEN_W'(PAT_W)) ? LEN_W'(PAT_W) : i_len;
    assign w_busy      = (r_state == ST_SEND) || (r_state == ST_GAP);
    assign w_abort     = i_abort && w_busy;
    assign w_empty     = (w_len_clamp == '0) || (i_reps == '0);
    assign w_rep_more  = (r_rep != REP_W'(1));

    // Each repetition restarts by reloading the captured pattern into the shifter.
    always_comb begin
        w_load   = 1'b0;
        w_shift  = 1'b0;
        w_ld_pat = r_pat;
        w_ld_len = r_len;
        if (w_abort) begin
            w_load   = 1'b1;
            w_ld_len = '0;
        end else begin
            case (r_state)
                ST_IDLE, ST_FIN: begin
                    if (i_start) begin
                        w_load   = 1'b1;
                        w_ld_pat = i_pat;
                        w_ld_len = w_empty ? '0 : w_len_clamp;
                    end
                end
                ST_SEND: begin
                    if (w_last && w_rep_more && (r_gap == '0)) begin
                        w_load = 1'b1;
                    end else begin
                        w_shift = 1'b1;
                    end
                end
                ST_GAP: begin
                    if (r_gap_cnt == GAP_W'(1)) begin
                        w_load = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    seq_shift_out #(
        .PAT_W    (PAT_W),
        .LEN_W    (LEN_W),
        .IDLE_BIT (IDLE_BIT)
    ) u_shift (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_load  (w_load),
        .i_shift (w_shift),
        .i_pat   (w_ld_pat),
        .i_len   (w_ld_len),
        .o_bit   (w_bit),
        .o_last  (w_last)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= ST_IDLE;
            r_pat     <= '0;
            r_len     <= '0;
            r_rep     <= '0;
            r_gap     <= '0;
            r_gap_cnt <= '0;
            r_vld     <= 1'b0;
        end else if (w_abort) begin
            r_state <= ST_IDLE;
            r_vld   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_FIN: begin
                    if (i_start) begin
                        r_pat <= i_pat;
                        r_len <= w_len_clamp;
                        r_rep <= i_reps;
                        r_gap <= i_gap;
                        if (w_empty) begin
                            r_state <= ST_FIN;
                            r_vld   <= 1'b0;
                        end else begin
                            r_state <= ST_SEND;
                            r_vld   <= 1'b1;
                        end
                    end else begin
                        r_state <= ST_IDLE;
                        r_vld   <= 1'b0;
                    end
                end
                ST_SEND: begin
                    if (w_last) begin
                        r_rep <= r_rep - REP_W'(1);
                        if (!w_rep_more) begin
                            r_state <= ST_FIN;
                            r_vld   <= 1'b0;
                        end else if (r_gap != '0) begin
                            r_state   <= ST_GAP;
                            r_gap_cnt <= r_gap;
                            r_vld     <= 1'b0;
                        end
                    end
                end
                ST_GAP: begin
                    r_gap_cnt <= r_gap_cnt - GAP_W'(1);
                    if (r_gap_cnt == GAP_W'(1)) begin
                        r_state <= ST_SEND;
                        r_vld   <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_vld   <= 1'b0;
                end
            endcase
        end
    end

    assign o_dout     = w_bit;
    assign o_dout_vld = r_vld;
    assign o_busy     = w_busy;
    assign o_done     = (r_state == ST_FIN);

endmodule
